alarm_event_uart_tx: RTL and testbench
======================================

Name: alarm_event_uart_tx

Overview:
- Serial transmitter that reports anti-theft state changes to a host PC over UART (8N1, LSB first).
- Watches the alarm FSM state code plus the status, siren and fuel_pump outputs. Snapshots every change into a small FIFO and serializes each snapshot as one byte on the board's USB-UART TX pin.
- Sits in the top level beside the display driver. It is the outbound counterpart of the switch-driven parameter and sensor inputs.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate; bit period BIT_DIV = CLK_HZ/BAUD, truncated (868 at defaults).
- FIFO_DEPTH, 4, snapshot FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- estado  in  4  alarm FSM state code.
- status  in  1  status LED level from the FSM.
- siren  in  1  siren output level.
- fuel_pump  in  1  fuel pump enable level.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky: a snapshot was dropped since reset.

Behaviour:
- Reset (reset low, asynchronous):
  - tx=1, busy=0, overflow=0.
  - FIFO emptied; shifter idle; baud counter 0.
  - Previous-snapshot register loaded with {estado,status,siren,fuel_pump} sampled on the first clock after release.
  - No byte is emitted for the reset value.
- Change detect:
  - snap = {estado,status,siren,fuel_pump} (7 bits), registered each cycle.
  - When snap differs from the previous snapshot, push one entry in that cycle and update the previous snapshot.
  - Multiple changes in consecutive cycles push one entry each.
- Byte format: bit7 = drop flag, bits6:3 = estado, bit2 = status, bit1 = siren, bit0 = fuel_pump.
  - drop flag = 1 on the first byte pushed after any dropped snapshot, then 0 again.
- FIFO full:
  - A push while full is discarded.
  - overflow goes to 1 and stays there until reset.
  - An internal pending-drop bit sets; it is cleared when the next snapshot is successfully pushed (that byte carries bit7=1).
  - A simultaneous push and pop when full is accepted (no drop).
- Transmit FSM:
  - IDLE: tx=1. If FIFO is non-empty, pop the head, load the shifter, enter START the next cycle.
  - START: tx=0 for BIT_DIV cycles.
  - DATA: 8 bits LSB first, BIT_DIV cycles each, 3-bit bit index.
  - STOP: tx=1 for BIT_DIV cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between a STOP and the next START.
- Latency:
  - tx falls 3 cycles after the clock edge at which the input change is sampled: input register, push, pop/start.
  - Frame length = 10*BIT_DIV cycles.
- Baud counter:
  - Counts 0..BIT_DIV-1 and is cleared on every state entry.
  - Width = clog2(BIT_DIV).
- busy = (state != IDLE) or FIFO non-empty, registered.
- Inputs are synchronous to clock (debounced upstream); no extra synchronizers.
- Reset mid-frame: tx returns to 1 immediately; the partial frame is abandoned and never resumed.

Decomposition:
- Shared package, alarm_pkg:
  - tx state enum: IDLE, START, DATA, STOP.
  - Snapshot bit-position constants for byte bit7..bit0.
  - UART frame constants: 8 data bits, 1 stop bit.
- One natural sub-module: sync_fifo (parameterized width/depth; full, empty, push, pop). It is instantiated with width 8, FIFO_DEPTH.
- Change detect, drop-flag logic and the shift FSM stay in the top of this block.

Test Plan:
- Reset release with estado=4'h0, others 0, held 20 k cycles -> tx stays 1, busy=0, no frame.
- estado 0->3 with status=1 at cycle T -> tx falls at T+3.
  - Frame byte 0x1C sent LSB first, each bit 868 cycles.
  - Stop bit high; busy low after 8680+ cycles.
- siren toggles 0->1->0 on consecutive cycles -> two frames back-to-back.
  - Bytes 0x02 then 0x00.
  - Exactly 1 idle cycle between the first stop bit and the second start bit.
- Eight distinct changes in eight consecutive cycles, FIFO_DEPTH=4:
  - Change 1 is popped immediately; changes 2..5 fill the FIFO; changes 6..8 are dropped.
  - overflow=1.
  - The next change after the FIFO drains one entry is sent with bit7=1.
- Assert reset in the middle of data bit 3 -> tx=1 asynchronously (before the next edge).
  - busy=0, overflow=0.
  - After release, no stale byte is sent.
- BAUD=9600 override -> bit period 10416 cycles; frame byte matches the scenario-2 value.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm event UART transmitter
package alarm_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Snapshot byte layout, bit7 down to bit0
  localparam int BIT_DROP      = 7;
  localparam int BIT_ESTADO_HI = 6;
  localparam int BIT_ESTADO_LO = 3;
  localparam int BIT_STATUS    = 2;
  localparam int BIT_SIREN     = 1;
  localparam int BIT_FUEL      = 0;

  localparam int SNAP_W    = 7;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with push-while-full-and-pop support
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alarm_event_uart_tx.sv
// rtl/alarm_event_uart_tx.sv - snapshots alarm state changes and sends each as one 8N1 UART byte
module alarm_event_uart_tx
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] estado,
  input  logic       status,
  input  logic       siren,
  input  logic       fuel_pump,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic [SNAP_W-1:0] snap_in;
  logic [SNAP_W-1:0] snap_q;
  logic [SNAP_W-1:0] prev_q;
  logic              primed_q;
  logic              change;
  logic              drop_pend_q;
  logic              overflow_q;

  logic [7:0] push_byte;
  logic [7:0] pop_byte;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       dropped;
  logic       accepted;

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             tx_q;
  logic             busy_q;

  assign snap_in = {estado, status, siren, fuel_pump};
  assign change  = primed_q && (snap_q != prev_q);

  always_comb begin
    push_byte = '0;
    push_byte[BIT_DROP]                    = drop_pend_q;
    push_byte[BIT_ESTADO_HI:BIT_ESTADO_LO] = snap_q[6:3];
    push_byte[BIT_STATUS]                  = snap_q[2];
    push_byte[BIT_SIREN]                   = snap_q[1];
    push_byte[BIT_FUEL]                    = snap_q[0];
  end

  assign fifo_pop = (state_q == TX_IDLE) && !fifo_empty;
  assign dropped  = change && fifo_full && !fifo_pop;
  assign accepted = change && !dropped;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (change),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .pop_data  (pop_byte),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // First clock after reset seeds the reference so the reset value never produces a byte
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_q      <= '0;
      prev_q      <= '0;
      primed_q    <= 1'b0;
      drop_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      snap_q <= snap_in;
      if (!primed_q) begin
        prev_q   <= snap_in;
        primed_q <= 1'b1;
      end else if (change) begin
        prev_q <= snap_q;
      end
      if (dropped) begin
        drop_pend_q <= 1'b1;
        overflow_q  <= 1'b1;
      end else if (accepted) begin
        drop_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          if (fifo_pop) begin
            shreg_q <= pop_byte;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            if (bit_idx_q == IDX_LAST) state_q <= TX_STOP;
            else                       bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Line and busy are registered off the state, so the line trails the FSM by one clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        TX_START: tx_q <= 1'b0;
        TX_DATA:  tx_q <= shreg_q[0];
        default:  tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != TX_IDLE) || !fifo_empty;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alarm_event_uart_tx.sv
// tb/tb_alarm_event_uart_tx.sv - scoreboard bench: UART monitors decode frames against queued expected bytes
module tb_alarm_event_uart_tx;

  localparam int DIV_B = 100_000_000 / 115200;
  localparam int DIV_S = 1_000_000 / 96_000;

  logic       clock = 1'b0;
  logic       rst_b;
  logic       rst_s;
  logic [3:0] estado;
  logic       status;
  logic       siren;
  logic       fuel_pump;
  logic       tx_b, busy_b, ovf_b;
  logic       tx_s, busy_s, ovf_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit         mon_en [2];
  int         starts [2];
  int         rx_cnt [2];
  logic [7:0] exp_b [$];
  logic [7:0] exp_s [$];
  int         start_b [$];
  int         start_s [$];

  alarm_event_uart_tx #(
    .CLK_HZ(100_000_000), .BAUD(115200), .FIFO_DEPTH(4)
  ) dut_b (
    .clock(clock), .reset(rst_b), .estado(estado), .status(status), .siren(siren),
    .fuel_pump(fuel_pump), .tx(tx_b), .busy(busy_b), .overflow(ovf_b)
  );

  alarm_event_uart_tx #(
    .CLK_HZ(1_000_000), .BAUD(96_000), .FIFO_DEPTH(4)
  ) dut_s (
    .clock(clock), .reset(rst_s), .estado(estado), .status(status), .siren(siren),
    .fuel_pump(fuel_pump), .tx(tx_s), .busy(busy_s), .overflow(ovf_s)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic cur_tx(input int w);
    return (w != 0) ? tx_s : tx_b;
  endfunction

  function automatic logic cur_rst(input int w);
    return (w != 0) ? rst_s : rst_b;
  endfunction

  task automatic monitor(input int w);
    int         div;
    int         s;
    int         bn;
    logic [7:0] b;
    logic       v;
    bit         ok;
    bit         abort;
    div = (w != 0) ? DIV_S : DIV_B;
    forever begin
      @(negedge clock);
      if (mon_en[w] && cur_rst(w) === 1'b1 && cur_tx(w) === 1'b0) begin
        s = cyc; ok = 1'b1; abort = 1'b0; b = '0;
        starts[w]++;
        for (int i = 0; i < 10 * div && !abort; i++) begin
          if (i > 0) @(negedge clock);
          if (cur_rst(w) !== 1'b1) begin
            abort = 1'b1;
          end else begin
            bn = i / div;
            v  = cur_tx(w);
            if (bn == 0) begin
              if (v !== 1'b0) ok = 1'b0;
            end else if (bn == 9) begin
              if (v !== 1'b1) ok = 1'b0;
            end else if (i % div == 0) begin
              b[bn-1] = v;
            end else if (v !== b[bn-1]) begin
              ok = 1'b0;
            end
          end
        end
        if (!abort) begin
          chk((w != 0) ? "s_frame_shape" : "b_frame_shape", {31'd0, ok}, 32'd1);
          if (w != 0) begin
            start_s.push_back(s);
            if (exp_s.size() == 0) chk("s_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
            else                   chk("s_frame_byte", {24'd0, b}, {24'd0, exp_s.pop_front()});
          end else begin
            start_b.push_back(s);
            if (exp_b.size() == 0) chk("b_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
            else                   chk("b_frame_byte", {24'd0, b}, {24'd0, exp_b.pop_front()});
          end
          rx_cnt[w]++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rx(input int w, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_cnt[w] < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, {31'd0, rx_cnt[w] >= n}, 32'd1);
  endtask

  initial begin
    int c;
    int s1;
    int s2;
    int st_before;
    estado = 4'h0; status = 1'b0; siren = 1'b0; fuel_pump = 1'b0;
    rst_b = 1'b0; rst_s = 1'b0;
    mon_en[0] = 1'b1; mon_en[1] = 1'b1;
    step(3);
    chk("rst_tx_b", {31'd0, tx_b}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_ovf_b", {31'd0, ovf_b}, 32'd0);
    chk("rst_tx_s", {31'd0, tx_s}, 32'd1);
    chk("rst_busy_s", {31'd0, busy_s}, 32'd0);

    rst_b = 1'b1; rst_s = 1'b1;
    step(20000);
    chk("idle_no_frame_b", starts[0], 32'd0);
    chk("idle_no_frame_s", starts[1], 32'd0);
    chk("idle_tx_b", {31'd0, tx_b}, 32'd1);
    chk("idle_busy_b", {31'd0, busy_b}, 32'd0);

    // estado 0->3 with status=1: byte 0x1C on both instances
    c = cyc;
    estado = 4'h3; status = 1'b1;
    exp_b.push_back(8'h1C); exp_s.push_back(8'h1C);
    wait_rx(1, 1, 400, "s_rx1_timeout");
    chk("s_latency", start_s.pop_front(), c + 4);
    chk("b_busy_mid_frame", {31'd0, busy_b}, 32'd1);
    wait_rx(0, 1, 12000, "b_rx1_timeout");
    chk("b_latency", start_b.pop_front(), c + 4);
    step(2);
    chk("b_busy_after", {31'd0, busy_b}, 32'd0);
    chk("b_tx_after", {31'd0, tx_b}, 32'd1);
    rst_b = 1'b0; mon_en[0] = 1'b0;

    estado = 4'h0; status = 1'b0;
    exp_s.push_back(8'h00);
    wait_rx(1, 2, 400, "s_rx2_timeout");
    step(3);
    start_s.delete();

    // siren pulse over two consecutive cycles: two frames with one idle cycle between
    c = cyc;
    siren = 1'b1; exp_s.push_back(8'h02);
    step(1);
    siren = 1'b0; exp_s.push_back(8'h00);
    wait_rx(1, 4, 600, "s_rx4_timeout");
    s1 = start_s.pop_front();
    s2 = start_s.pop_front();
    chk("s_b2b_first_start", s1, c + 4);
    chk("s_b2b_gap", s2 - s1, 10 * DIV_S + 1);
    step(3);
    chk("s_busy_idle", {31'd0, busy_s}, 32'd0);

    // eight changes in a row: 1..5 kept, 6..8 dropped
    for (int k = 1; k <= 8; k++) begin
      estado = 4'(k);
      if (k <= 5) exp_s.push_back(8'(k << 3));
      step(1);
    end
    step(2);
    chk("s_overflow_set", {31'd0, ovf_s}, 32'd1);
    wait_rx(1, 5, 400, "s_rx5_timeout");
    step(2);
    estado = 4'h9; exp_s.push_back(8'hC8);
    wait_rx(1, 6, 400, "s_rx6_timeout");
    step(2);
    estado = 4'hA; exp_s.push_back(8'h50);
    wait_rx(1, 11, 1000, "s_rx11_timeout");
    chk("s_overflow_sticky", {31'd0, ovf_s}, 32'd1);
    step(3);

    // reset in the middle of data bit 3
    c = cyc;
    st_before = starts[1];
    estado = 4'h5; fuel_pump = 1'b1; exp_s.push_back(8'h29);
    step(4 + 4 * DIV_S + DIV_S / 2);
    rst_s = 1'b0;
    #1;
    chk("s_async_tx", {31'd0, tx_s}, 32'd1);
    chk("s_rst_busy", {31'd0, busy_s}, 32'd0);
    chk("s_rst_ovf", {31'd0, ovf_s}, 32'd0);
    exp_s.delete();
    step(2);
    rst_s = 1'b1;
    step(20 * DIV_S);
    chk("s_no_stale_rx", rx_cnt[1], 32'd11);
    chk("s_no_stale_start", starts[1], st_before + 1);
    chk("s_tx_after_rst", {31'd0, tx_s}, 32'd1);

    estado = 4'h2; fuel_pump = 1'b0; exp_s.push_back(8'h10);
    wait_rx(1, 12, 400, "s_rx12_timeout");
    chk("s_scoreboard_empty", exp_s.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
